// File: rtl/xm23_dev_pkg.sv
// Shared XM23 device definitions: device indices, CSR bit layout, interrupt FSM states.
package xm23_dev_pkg;

  localparam int DEV_TIMER  = 0;
  localparam int DEV_KB     = 1;
  localparam int DEV_SCREEN = 2;
  localparam int DEV_TL     = 3;
  localparam int DEV_PB     = 4;

  localparam int CSR_IE     = 0;
  localparam int CSR_DBA    = 2;
  localparam int CSR_OF     = 3;
  localparam int CSR_PRI_LO = 5;
  localparam int CSR_PRI_W  = 3;

  localparam logic [3:0] VEC_BASE_DEF = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } int_state_e;

  function automatic logic [2:0] csr_pri(input logic [7:0] csr);
    return csr[CSR_PRI_LO +: CSR_PRI_W];
  endfunction

endpackage

// File: rtl/int_prio_sel.sv
// Combinational interrupt winner selection: highest priority among eligible sources,
// ties resolved by the first index found searching cyclically from 'start'.
module int_prio_sel #(
  parameter int NDEV = 5,
  parameter int IW   = (NDEV > 1) ? $clog2(NDEV) : 1
) (
  input  logic [NDEV-1:0]   elig,
  input  logic [3*NDEV-1:0] pri,
  input  logic [IW-1:0]     start,
  output logic [IW-1:0]     idx,
  output logic              valid
);

  logic [2:0] max_pri_s;
  logic       found_s;
  int         pos_s;

  // Find the highest priority, then the first matching source from the start pointer
  always_comb begin
    max_pri_s = 3'd0;
    valid     = 1'b0;
    idx       = '0;
    found_s   = 1'b0;
    pos_s     = 0;
    for (int i = 0; i < NDEV; i++) begin
      if (elig[i] && (!valid || (pri[3*i +: 3] > max_pri_s))) begin
        max_pri_s = pri[3*i +: 3];
        valid     = 1'b1;
      end else begin
        max_pri_s = max_pri_s;
      end
    end
    for (int k = 0; k < NDEV; k++) begin
      pos_s = int'(start) + k;
      if (pos_s >= NDEV) begin
        pos_s = pos_s - NDEV;
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && elig[pos_s] && (pri[3*pos_s +: 3] == max_pri_s)) begin
        idx     = pos_s[IW-1:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// XM23 interrupt controller: DBA edge capture, priority arbitration, IDLE/REQ/HOLD handshake.
// Optional macro INT_CTRL_RR_TIE_EN enables round-robin tie breaking after each ack.
module int_ctrl
  import xm23_dev_pkg::*;
#(
  parameter int         NDEV     = 5,
  parameter logic [3:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [8*NDEV-1:0] dev_csr,
  input  logic [2:0]        cpu_pri,
  input  logic              int_ack,
  output logic              int_req,
  output logic [3:0]        vect_num,
  output logic [2:0]        int_pri,
  output logic [NDEV-1:0]   pend
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

  int_state_e        state_r, state_n;
  logic [NDEV-1:0]   pend_r, pend_n, dba_hist_r, clr_s;
  logic [NDEV-1:0]   ie_s, dba_s, elig_s, rise_s;
  logic [3*NDEV-1:0] pri_s;
  logic              armed_r;
  logic [IW-1:0]     win_idx_r, win_idx_n, sel_idx_s, start_s;
  logic              sel_valid_s, ack_s;
  logic              req_r, req_n;
  logic [3:0]        vect_r, vect_n;
  logic [2:0]        pri_r, pri_n;
  logic              unused_csr_s;

  // Per-source CSR field decode and eligibility
  always_comb begin
    ie_s   = '0;
    dba_s  = '0;
    pri_s  = '0;
    elig_s = '0;
    for (int i = 0; i < NDEV; i++) begin
      ie_s[i]        = dev_csr[8*i + CSR_IE];
      dba_s[i]       = dev_csr[8*i + CSR_DBA];
      pri_s[3*i +: 3] = csr_pri(dev_csr[8*i +: 8]);
      elig_s[i]      = pend_r[i] & ie_s[i] & (pri_s[3*i +: 3] > cpu_pri);
    end
  end

  // The first sample after reset only seeds history, so a DBA already high is not an edge
  assign rise_s       = dba_s & ~dba_hist_r & {NDEV{armed_r}};
  assign unused_csr_s = ^{dev_csr, ack_s};

  int_prio_sel #(
    .NDEV (NDEV),
    .IW   (IW)
  ) u_sel (
    .elig  (elig_s),
    .pri   (pri_s),
    .start (start_s),
    .idx   (sel_idx_s),
    .valid (sel_valid_s)
  );

`ifdef INT_CTRL_RR_TIE_EN
  logic [IW-1:0] ptr_r;

  // Round-robin pointer: search begins just after the last acknowledged source
  always_ff @(negedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_r <= '0;
    end else if (ack_s) begin
      ptr_r <= (int'(win_idx_r) == NDEV - 1) ? '0 : win_idx_r + 1'b1;
    end
  end

  assign start_s = ptr_r;
`else
  assign start_s = '0;
`endif

  // Next-state and next-output logic; a latched winner is never pre-empted
  always_comb begin
    state_n   = state_r;
    win_idx_n = win_idx_r;
    vect_n    = vect_r;
    pri_n     = pri_r;
    req_n     = 1'b0;
    clr_s     = '0;
    ack_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_n   = ST_REQ;
          win_idx_n = sel_idx_s;
          vect_n    = 4'(VEC_BASE + 4'(sel_idx_s));
          pri_n     = pri_s[3*int'(sel_idx_s) +: 3];
          req_n     = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          clr_s[win_idx_r] = 1'b1;
          ack_s            = 1'b1;
          state_n          = ST_HOLD;
        end else if (!elig_s[win_idx_r]) begin
          state_n = ST_IDLE;
        end else begin
          req_n = 1'b1;
        end
      end
      ST_HOLD: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // A new edge on the acknowledged source beats the clear
    pend_n = (pend_r & ~clr_s) | rise_s;
  end

  // State, pending flags, edge history and registered outputs
  always_ff @(negedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= ST_IDLE;
      pend_r     <= '0;
      dba_hist_r <= '0;
      armed_r    <= 1'b0;
      win_idx_r  <= '0;
      req_r      <= 1'b0;
      vect_r     <= 4'd0;
      pri_r      <= 3'd0;
    end else begin
      state_r    <= state_n;
      pend_r     <= pend_n;
      dba_hist_r <= dba_s;
      armed_r    <= 1'b1;
      win_idx_r  <= win_idx_n;
      req_r      <= req_n;
      vect_r     <= vect_n;
      pri_r      <= pri_n;
    end
  end

  assign int_req  = req_r;
  assign vect_num = vect_r;
  assign int_pri  = pri_r;
  assign pend     = pend_r;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NDEV, default 5, meaning the number of device sources (0=timer, 1=keyboard, 2=screen, 3=traffic light, 4=pedestrian button).
REQ-002 SHALL have parameter VEC_BASE, default 4'd8, meaning the vector number of device 0; device i uses VEC_BASE+i.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its negedge, matching the CPU register update edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dev_csr, input, 8*NDEV bits: device CSR i at bits [8i+7:8i]; bit0 IE, bit2 DBA, bit3 OF, bits[7:5] device priority.
REQ-006 SHALL have port cpu_pri, input, 3 bits: the current CPU priority from PSW[7:5].
REQ-007 SHALL have port int_ack, input, 1 bit: a one-cycle pulse from the control unit when it accepts the request.
REQ-008 SHALL have port int_req, output, 1 bit: an interrupt request to the control unit.
REQ-009 SHALL have port vect_num, output, 4 bits: the vector of the granted source.
REQ-010 SHALL have port int_pri, output, 3 bits: the priority of the granted source.
REQ-011 SHALL have port pend, output, NDEV bits: the pending-source flags.

Function
REQ-012 SHALL set pend[i] on a rising edge of dev_csr DBA(i) (0->1 between consecutive negedges); edge history SHALL be kept per source.
REQ-013 SHALL keep pend[i] set until source i is acknowledged; IE=0 SHALL NOT clear pend[i], it SHALL only mask it.
REQ-014 SHALL treat source i as eligible when pend[i]=1, IE(i)=1, and pri(i) > cpu_pri (strictly greater).
REQ-015 SHALL choose the winner among eligible sources by highest pri; on a tie, the lowest index SHALL win.
REQ-016 SHALL use a state machine with states IDLE, REQ and HOLD.
REQ-017 In IDLE, when any source is eligible, SHALL latch the winner index, vect_num and int_pri, and move to REQ.
REQ-018 In REQ, SHALL hold int_req=1 and keep vect_num and int_pri stable.
REQ-019 In REQ, when int_ack=1, SHALL clear pend[winner], set int_req=0 and move to HOLD.
REQ-020 In REQ, when the latched winner becomes ineligible without int_ack, SHALL drop int_req and return to IDLE, keeping pend unchanged.
REQ-021 In REQ, a newly eligible higher-priority source SHALL NOT pre-empt the latched winner.
REQ-022 HOLD SHALL last exactly one cycle with int_req=0, then move to IDLE; this lets cpu_pri update before the next arbitration.
REQ-023 Latency: a DBA edge sampled at negedge n SHALL give pend at n, the state REQ with int_req=1 at n+1, and the earliest possible re-request after an ack at 2 cycles.
REQ-024 SHALL ignore int_ack in IDLE and HOLD.
REQ-025 When a new DBA edge on the winner coincides with int_ack, the set SHALL win and pend[winner] SHALL stay 1.
REQ-026 vect_num SHALL be computed as VEC_BASE+index, truncated to 4 bits; it wraps modulo 16.

Reset
REQ-027 Reset_n=0 SHALL asynchronously force state=IDLE, pend=0, DBA history=0, int_req=0, vect_num=0 and int_pri=0.
REQ-028 Reset during REQ SHALL drop int_req immediately, and any in-flight ack SHALL be lost.
REQ-029 After reset release, a DBA already high SHALL NOT create a pending flag; only a later edge SHALL.

Configuration
REQ-030 With INT_CTRL_RR_TIE_EN defined, ties SHALL be broken round-robin: the search starts at the index after the last acknowledged source, and the pointer resets to 0.
REQ-031 With INT_CTRL_RR_TIE_EN undefined, ties SHALL use fixed lowest-index priority per REQ-015, and no pointer register SHALL exist.

Structure
REQ-032 Device index constants, CSR bit positions (IE=0, DBA=2, OF=3, PRI=7:5), the state enum and the VEC_BASE default SHALL live in shared package xm23_dev_pkg.
REQ-033 The combinational winner selection SHALL be one sub-module, int_prio_sel, which takes the eligible mask, the priorities and an optional start pointer, and returns the index and a valid flag.

Verification
REQ-034 Timer IE=1 pri=3, cpu_pri=1, DBA 0->1 -> pend[0]=1 at that edge; int_req=1, vect_num=8, int_pri=3 one cycle later.
REQ-035 KB pri=5 and PB pri=2 pending, cpu_pri=0 -> vect 9 first; ack -> HOLD 1 cycle -> vect 12 requested.
REQ-036 Screen pri=4, cpu_pri=4 -> no int_req; then cpu_pri=3 -> int_req=1, vect_num=10.
REQ-037 In REQ for TL, clear TL IE before ack -> int_req=0 next edge, pend[3] stays 1; set IE=1 -> request again.
REQ-038 Ack coincident with a new TL DBA edge -> pend[3] stays 1, re-request 2 cycles later; Reset_n low mid-REQ -> int_req=0 and pend=0 immediately.
REQ-039 With INT_CTRL_RR_TIE_EN defined, timer and KB both pri 3, repeated events -> grants alternate 8, 9, 8, 9; with it undefined, timer wins each tie.
